// File: rtl/debug_pkg.sv
// rtl/debug_pkg.sv - command bytes, frame defaults and state encodings for the pipeline debug unit
package debug_pkg;

  localparam logic [7:0] CMD_RUN  = 8'h43;
  localparam logic [7:0] CMD_HALT = 8'h48;
  localparam logic [7:0] CMD_STEP = 8'h53;
  localparam logic [7:0] CMD_DUMP = 8'h44;

  localparam int         NUM_WORDS_DEF = 40;
  localparam logic [7:0] HDR_BYTE_DEF  = 8'hA5;
  localparam int         SEL_W_DEF     = 6;

  // D_SEND covers the byte/wait handshake, which lives in the serializer FSM
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RUN,
    ST_STEP,
    ST_D_HDR,
    ST_D_LOAD,
    ST_D_SEND
  } ctl_state_t;

  typedef enum logic [1:0] {
    SER_IDLE,
    SER_BYTE,
    SER_WAIT
  } ser_state_t;

endpackage

// File: rtl/debug_word_serializer.sv
// rtl/debug_word_serializer.sv - sends 1..4 bytes of a loaded word MSB first over a start/busy handshake
module debug_word_serializer
  import debug_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [31:0] load_data,
  input  logic [1:0]  load_last,
  input  logic        tx_busy,
  output logic [7:0]  tx_data,
  output logic        tx_start,
  output logic        done
);

  ser_state_t  state, state_next;
  logic [31:0] shift;
  logic [1:0]  remaining;
  logic        first;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= SER_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    tx_start   = 1'b0;
    done       = 1'b0;
    case (state)
      SER_IDLE: if (load) state_next = SER_BYTE;
      SER_BYTE: begin
        if (!tx_busy) begin
          tx_start   = 1'b1;
          state_next = SER_WAIT;
        end
      end
      SER_WAIT: begin
        // busy only rises the cycle after tx_start, so the first wait cycle is not trusted
        if (!first && !tx_busy) begin
          if (remaining == 2'd0) begin
            done       = 1'b1;
            state_next = SER_IDLE;
          end else begin
            state_next = SER_BYTE;
          end
        end
      end
      default: state_next = SER_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift     <= '0;
      remaining <= '0;
      first     <= 1'b0;
    end else begin
      if (state == SER_IDLE && load) begin
        shift     <= load_data;
        remaining <= load_last;
      end
      if (tx_start) first <= 1'b1;
      else          first <= 1'b0;
      if (state == SER_WAIT && !first && !tx_busy && remaining != 2'd0) begin
        shift     <= {shift[23:0], 8'h00};
        remaining <= remaining - 2'd1;
      end
    end
  end

  assign tx_data = shift[31:24];

endmodule

// File: rtl/pipeline_debug_unit.sv
// rtl/pipeline_debug_unit.sv - run/halt/step clock gating and state-dump framing for the MIPS pipeline
module pipeline_debug_unit
  import debug_pkg::*;
#(
  parameter int         NUM_WORDS = NUM_WORDS_DEF,
  parameter logic [7:0] HDR_BYTE  = HDR_BYTE_DEF,
  parameter int         SEL_W     = SEL_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       rx_data,
  input  logic             rx_valid,
  output logic [7:0]       tx_data,
  output logic             tx_start,
  input  logic             tx_busy,
  input  logic             halt_detect,
  output logic [SEL_W-1:0] dump_sel,
  input  logic [31:0]      dump_word,
  output logic             pipe_clk_en,
  output logic             debug_mode
);

  localparam logic [SEL_W:0] LAST_IDX = (SEL_W + 1)'(NUM_WORDS);

  ctl_state_t     state, state_next;
  logic [31:0]    step_cnt;
  logic [31:0]    step_snap;
  logic [SEL_W:0] word_idx;
  logic           hdr_phase;
  logic           ser_load;
  logic [31:0]    ser_data;
  logic [1:0]     ser_last;
  logic           ser_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    ser_load   = 1'b0;
    ser_data   = '0;
    ser_last   = 2'd3;
    case (state)
      ST_IDLE: begin
        if (rx_valid) begin
          case (rx_data)
            CMD_RUN:  state_next = ST_RUN;
            CMD_STEP: state_next = ST_STEP;
            CMD_DUMP: state_next = ST_D_HDR;
            default:  state_next = ST_IDLE;
          endcase
        end
      end
      ST_RUN: begin
        if (halt_detect)                              state_next = ST_D_HDR;
        else if (rx_valid && rx_data == CMD_HALT)     state_next = ST_IDLE;
      end
      ST_STEP: state_next = ST_D_HDR;
      ST_D_HDR: begin
        ser_load   = 1'b1;
        ser_data   = {HDR_BYTE, 24'h000000};
        ser_last   = 2'd0;
        state_next = ST_D_SEND;
      end
      ST_D_LOAD: begin
        // dump_sel has been stable for this whole cycle, so dump_word is settled here
        ser_load   = 1'b1;
        ser_data   = (word_idx == LAST_IDX) ? step_snap : dump_word;
        state_next = ST_D_SEND;
      end
      ST_D_SEND: begin
        if (ser_done) begin
          if (!hdr_phase && word_idx == LAST_IDX) state_next = ST_IDLE;
          else                                    state_next = ST_D_LOAD;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step_cnt  <= '0;
      step_snap <= '0;
      word_idx  <= '0;
      hdr_phase <= 1'b0;
    end else begin
      step_cnt <= step_cnt + {31'd0, pipe_clk_en};
      if (state == ST_D_HDR) begin
        step_snap <= step_cnt;
        word_idx  <= '0;
        hdr_phase <= 1'b1;
      end
      if (state == ST_D_SEND && ser_done) begin
        if (hdr_phase)                 hdr_phase <= 1'b0;
        else if (word_idx != LAST_IDX) word_idx  <= word_idx + 1'b1;
      end
    end
  end

  debug_word_serializer u_serializer (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (ser_load),
    .load_data (ser_data),
    .load_last (ser_last),
    .tx_busy   (tx_busy),
    .tx_data   (tx_data),
    .tx_start  (tx_start),
    .done      (ser_done)
  );

  assign dump_sel    = word_idx[SEL_W-1:0];
  assign pipe_clk_en = (state == ST_RUN) || (state == ST_STEP);
  assign debug_mode  = (state != ST_RUN);

endmodule

// File: tb/tb_pipeline_debug_unit.sv
// tb/tb_pipeline_debug_unit.sv - directed and randomized checks of run/step control and dump frames
module tb_pipeline_debug_unit;

  localparam int NW        = 40;
  localparam int FRAME_LEN = 1 + 4 * (NW + 1);

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        tx_busy = 1'b0;
  logic        halt_detect = 1'b0;
  logic [5:0]  dump_sel;
  logic [31:0] dump_word;
  logic        pipe_clk_en;
  logic        debug_mode;

  logic [31:0] word_seed = 32'h0;
  int          busy_max = 4;
  int          n_cmp = 0;
  int          n_bad = 0;
  int          en_cnt = 0;
  int          viol = 0;
  int          busy_left = 0;
  logic        prev_start = 1'b0;
  logic [7:0]  txq[$];
  logic [31:0] steps;

  pipeline_debug_unit dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .tx_data     (tx_data),
    .tx_start    (tx_start),
    .tx_busy     (tx_busy),
    .halt_detect (halt_detect),
    .dump_sel    (dump_sel),
    .dump_word   (dump_word),
    .pipe_clk_en (pipe_clk_en),
    .debug_mode  (debug_mode)
  );

  always #5 clk = ~clk;

  assign dump_word = (32'(dump_sel) * 32'h01010101) ^ word_seed;

  // Transmitter side: capture bytes, police the handshake
  always @(negedge clk) begin
    if (rst_n) begin
      if (pipe_clk_en) en_cnt++;
      if (tx_start) begin
        if (tx_busy || prev_start) viol++;
        txq.push_back(tx_data);
      end else if (tx_busy && txq.size() > 0 && tx_data !== txq[$]) begin
        viol++;
      end
      prev_start = tx_start;
    end else begin
      prev_start = 1'b0;
    end
  end

  always @(posedge clk) begin
    #1;
    if (!rst_n) begin
      tx_busy   = 1'b0;
      busy_left = 0;
    end else if (prev_start) begin
      tx_busy   = 1'b1;
      busy_left = $urandom_range(busy_max, 1);
    end else if (tx_busy) begin
      busy_left--;
      if (busy_left <= 0) tx_busy = 1'b0;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    rx_data  = 8'($urandom);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_tx_start"}, tx_start, 1'b0);
    check({tag, "_tx_data"}, tx_data, 8'h00);
    check({tag, "_dump_sel"}, dump_sel, 6'd0);
    check({tag, "_pipe_clk_en"}, pipe_clk_en, 1'b0);
    check({tag, "_debug_mode"}, debug_mode, 1'b1);
  endtask

  // Expected frame: header, NW words from the sel-dependent pattern, then the step count
  task automatic expect_frame(input string tag, input int start, input logic [31:0] step_exp);
    logic [7:0]  e[$];
    logic [31:0] w;
    int          waited = 0;
    int          bad = 0;
    int          en0;
    tick(2);
    en0 = en_cnt;
    e.push_back(8'hA5);
    for (int i = 0; i <= NW; i++) begin
      w = (i == NW) ? step_exp : ((i * 32'h01010101) ^ word_seed);
      for (int b = 3; b >= 0; b--) e.push_back(w[b*8 +: 8]);
    end
    while (txq.size() < start + FRAME_LEN && waited < 12000) begin
      @(negedge clk);
      waited++;
    end
    check({tag, "_complete"}, 32'(txq.size() >= start + FRAME_LEN), 32'd1);
    if (txq.size() >= start + FRAME_LEN) begin
      for (int i = 0; i < FRAME_LEN; i++) if (txq[start+i] !== e[i]) bad++;
      check({tag, "_hdr"}, txq[start], 8'hA5);
      check({tag, "_step_word"}, {txq[start+FRAME_LEN-4], txq[start+FRAME_LEN-3],
                                  txq[start+FRAME_LEN-2], txq[start+FRAME_LEN-1]}, step_exp);
      check({tag, "_bad_bytes"}, bad, 0);
    end
    tick(30);
    check({tag, "_no_extra"}, txq.size(), start + FRAME_LEN);
    check({tag, "_frozen"}, en_cnt - en0, 0);
    check({tag, "_idle_en"}, pipe_clk_en, 1'b0);
  endtask

  initial begin
    int start;
    int en0;
    int hold;
    int waited;
    int sz;

    // 1: reset values, single step and its auto-dump
    tick(1);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    tick(2);
    steps = 0;
    en0   = en_cnt;
    start = txq.size();
    send(8'h53);
    steps = steps + 1;
    expect_frame("step", start, steps);
    check("step_en_cycles", en_cnt - en0, 1);

    // 2: free run for a fixed then random number of cycles, then dump
    do_reset();
    steps = 0;
    for (int k = 0; k < 3; k++) begin
      hold = (k == 0) ? 100 : $urandom_range(40, 3);
      en0  = en_cnt;
      send(8'h43);
      tick(hold - 1);
      check("run_debug_mode", debug_mode, 1'b0);
      send(8'h48);
      tick(2);
      check("run_en_cycles", en_cnt - en0, hold);
      steps = steps + hold;
      word_seed = $urandom;
      start = txq.size();
      send(8'h44);
      expect_frame("dump_run", start, steps);
    end

    // 3/4: halt_detect with simultaneous 'H', slow and variable transmitter
    word_seed = 32'h0;
    busy_max  = 20;
    hold      = $urandom_range(30, 10);
    en0       = en_cnt;
    start     = txq.size();
    send(8'h43);
    tick(hold - 1);
    halt_detect = 1'b1;
    rx_data     = 8'h48;
    rx_valid    = 1'b1;
    @(negedge clk);
    halt_detect = 1'b0;
    rx_valid    = 1'b0;
    steps = steps + hold;
    expect_frame("halt_dump", start, steps);
    check("halt_en_cycles", en_cnt - en0, hold);

    // 5: run command mid-dump is dropped; step counter wrap
    busy_max  = 6;
    word_seed = $urandom;
    start     = txq.size();
    send(8'h44);
    tick(40);
    send(8'h43);
    expect_frame("dump_ignore_c", start, steps);
    force dut.step_cnt = 32'hFFFFFFFF;
    tick(2);
    release dut.step_cnt;
    tick(1);
    steps = 32'hFFFFFFFF;
    start = txq.size();
    send(8'h53);
    steps = steps + 1;
    expect_frame("wrap", start, steps);

    // 6: reset in the middle of a frame, then a fresh frame
    busy_max = 3;
    start    = txq.size();
    send(8'h44);
    waited = 0;
    while (txq.size() < start + 50 && waited < 5000) begin
      @(negedge clk);
      waited++;
    end
    check("midreset_reached", 32'(txq.size() >= start + 50), 32'd1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("midreset");
    sz = txq.size();
    tick(10);
    check("midreset_quiet", txq.size(), sz);
    rst_n = 1'b1;
    tick(2);
    steps = 0;
    start = txq.size();
    send(8'h44);
    expect_frame("after_reset", start, steps);

    check("protocol_violations", viol, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
